key_input_conditioner: RTL and testbench

//   Input-side counterpart of the HEX/LED display path. Cleans the active-low

---
 rtl/key_pkg.sv | 10 +
 rtl/key_debounce_chan.sv | 77 +++++++
 rtl/key_input_conditioner.sv | 33 +++
 tb/tb_key_input_conditioner.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: repeat FSM state encoding and shared counter-width helper
package key_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key (clk, rst, key_n active-low in) -> sync, debounce, level/press/rel/rep pulses out
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic rep
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [W-1:0] DB_END = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] RD_END = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] RP_END = W'(REPEAT_PERIOD - 1);
  logic s1, s2, raw, flip, rise, fall, rep_nxt;
  logic [W-1:0] cnt, tmr, tmr_nxt;
  rep_state_e state, state_nxt;
  assign raw  = ~s2;
  assign flip = (raw != level) && (cnt == DB_END);
  assign rise = flip & raw;
  assign fall = flip & ~raw;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      state <= IDLE;
      tmr   <= '0;
      rep   <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      cnt   <= (raw == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? raw : level;
      press <= rise;
      rel   <= fall;
      state <= state_nxt;
      tmr   <= tmr_nxt;
      rep   <= rep_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr + 1'b1;
    rep_nxt   = 1'b0;
    case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (rise && REPEAT_DELAY != 0) state_nxt = DELAY;
      end
      DELAY: if (tmr == RD_END) begin
        state_nxt = REPEAT;
        tmr_nxt   = '0;
        rep_nxt   = 1'b1;
      end
      REPEAT: if (tmr == RP_END) begin
        tmr_nxt = '0;
        rep_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (fall) begin
      state_nxt = IDLE;
      tmr_nxt   = '0;
      rep_nxt   = 1'b0;
    end
  end
endmodule

// File: rtl/key_input_conditioner.sv
// key_input_conditioner: CLOCK_50/reset, raw KEY_N in -> per-key key_level, key_press, key_release, key_repeat out
module key_input_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY_N,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk  (CLOCK_50),
      .rst  (reset),
      .key_n(KEY_N[i]),
      .level(key_level[i]),
      .press(key_press[i]),
      .rel  (key_release[i]),
      .rep  (key_repeat[i])
    );
  end
endmodule

// File: tb/tb_key_input_conditioner.sv
// tb_key_input_conditioner: scoreboard bench against a windowed reference model of the key conditioner
module tb_key_input_conditioner;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic [3:0] lvl0, prs0, rel0, rep0;
  exp_t expq[$];
  exp_t ex;
  logic [3:0] samp[$];
  bit rawq[4][$];
  logic [3:0] lvl;
  int pe[4];
  int ecount = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  key_input_conditioner #(.N_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLOCK_50(clk), .reset(rst), .KEY_N(key_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat)
  );
  key_input_conditioner #(.N_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut0 (
    .CLOCK_50(clk), .reset(rst), .KEY_N(key_n),
    .key_level(lvl0), .key_press(prs0), .key_release(rel0), .key_repeat(rep0)
  );
  task automatic chk(input string n, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at edge-cycle t=%0t: got %b expected %b", n, $time, got, want);
    end
  endtask
  // A key's level flips once the synchronised (two-edge delayed) input has
  // disagreed with it for D consecutive edges; repeats fall on press+RD+k*RP while held.
  task automatic model();
    exp_t x;
    logic [3:0] raw;
    bit flip;
    ecount++;
    x = '0;
    if (rst) begin
      samp = '{4'hF, 4'hF};
      for (int i = 0; i < 4; i++) rawq[i].delete();
      lvl = '0;
    end else begin
      samp.push_back(key_n);
      if (samp.size() > 3) void'(samp.pop_front());
      raw = ~samp[0];
      for (int i = 0; i < 4; i++) begin
        rawq[i].push_back(raw[i]);
        if (rawq[i].size() > D) void'(rawq[i].pop_front());
        flip = (rawq[i].size() == D);
        foreach (rawq[i][j]) if (rawq[i][j] == lvl[i]) flip = 0;
        if (flip) begin
          lvl[i] = raw[i];
          x.press[i] = raw[i];
          x.rel[i] = ~raw[i];
          if (raw[i]) pe[i] = ecount;
        end
        x.rep[i] = lvl[i] && !x.press[i] && (ecount - pe[i]) >= RD && ((ecount - pe[i] - RD) % RP) == 0;
      end
    end
    x.level = lvl;
    expq.push_back(x);
  endtask
  task automatic cyc(input logic [3:0] k, input logic r);
    key_n = k;
    rst = r;
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  task automatic hold(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) cyc(k, 1'b0);
  endtask
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ex = expq.pop_front();
      chk("key_level", key_level, ex.level);
      chk("key_press", key_press, ex.press);
      chk("key_release", key_release, ex.rel);
      chk("key_repeat", key_repeat, ex.rep);
      chk("norep_level", lvl0, ex.level);
      chk("norep_press", prs0, ex.press);
      chk("norep_repeat", rep0, 4'b0000);
    end
  end
  initial begin
    int run[4];
    logic [3:0] kv;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1);
    hold(4'b0000, 10);
    hold(4'b1111, 10);
    hold(4'b0111, 12);
    hold(4'b1111, 12);
    hold(4'b1110, 3);
    hold(4'b1111, 1);
    hold(4'b1110, 2);
    hold(4'b1111, 1);
    hold(4'b1110, 12);
    hold(4'b1111, 12);
    hold(4'b1101, 36);
    hold(4'b1111, 15);
    hold(4'b1101, 13);
    hold(4'b1111, 12);
    hold(4'b1011, 20);
    cyc(4'b1011, 1'b1);
    hold(4'b1011, 25);
    hold(4'b1111, 12);
    kv = 4'hF;
    run = '{0, 0, 0, 0};
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (run[i] == 0) begin
          kv[i] = ~kv[i];
          run[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end
        run[i]--;
      end
      cyc(kv, $urandom_range(0, 299) == 0);
    end
    hold(4'b1111, 12);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
